// File: rtl/core_pipe_mem_if.sv
// Data-RAM bus between the memory stage (master) and the data RAM (slave).
// One request is outstanding at a time; the master holds it until ram_ack.
interface core_pipe_mem_if;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/core_pipe_mem.sv
// Memory pipeline stage: takes one instruction from execute, performs its
// data-RAM access if it has one, and presents the writeback/forwarding bundle.
module core_pipe_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ie_validout,
  output logic        mem_allowin,
  input  logic [4:0]  ie_rd,
  input  logic        result_mem_load,
  input  logic        result_mem_store,
  input  logic [1:0]  result_mem_size,
  input  logic        ie_mem_unsigned,
  input  logic [31:0] result_mem_addr,
  input  logic [31:0] result_mem_din,
  input  logic        result_computed,
  input  logic [31:0] result_value,
  input  logic        result_link,
  input  logic [31:0] result_link_addr,
  core_pipe_mem_if.master ram,
  output logic        mem_validout,
  input  logic        wb_allowin,
  output logic [4:0]  mem_rd,
  output logic        mem_result_mem_load,
  output logic        mem_result_computed,
  output logic [31:0] mem_result_value,
  output logic [31:0] ram_dout,
  output logic        mem_misalign
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t      state, state_nx, capture_state;
  logic        capture, is_load, is_store, is_mem, aligned;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in, lane, load_fmt;

  logic        ld_q, we_q, uns_q, computed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  // Load wins when both request bits are set.
  assign is_load  = result_mem_load;
  assign is_store = result_mem_store & ~result_mem_load;
  assign is_mem   = is_load | is_store;

  assign mem_validout = (state == HOLD);
  assign mem_allowin  = ((state == IDLE) & ~mem_validout) | ((state == HOLD) & wb_allowin);
  assign capture      = ie_validout & mem_allowin;

  assign ram.ram_req   = (state == ACCESS);
  assign ram.ram_we    = (state == ACCESS) & we_q;
  assign ram.ram_addr  = {addr_q[31:2], 2'b00};
  assign ram.ram_wdata = wdata_q;
  assign ram.ram_wstrb = wstrb_q;

  assign mem_result_mem_load = ld_q & mem_validout;
  assign mem_result_computed = computed_q & mem_validout;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    aligned  = 1'b1;
    wstrb_in = 4'b1111;
    wdata_in = result_mem_din;
    unique case (result_mem_size)
      2'b00: begin
        wstrb_in = 4'b0001 << result_mem_addr[1:0];
        wdata_in = {4{result_mem_din[7:0]}};
      end
      2'b01: begin
        aligned  = ~result_mem_addr[0];
        wstrb_in = 4'b0011 << result_mem_addr[1:0];
        wdata_in = {2{result_mem_din[15:0]}};
      end
      default: aligned = (result_mem_addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    lane     = ram.ram_rdata >> {addr_q[1:0], 3'b000};
    load_fmt = lane;
    unique case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & lane[7]}},  lane[7:0]};
      2'b01:   load_fmt = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    capture_state = (is_mem & aligned) ? ACCESS : HOLD;
    state_nx      = state;
    unique case (state)
      IDLE:    if (capture) state_nx = capture_state;
      ACCESS:  if (ram.ram_ack) state_nx = HOLD;
      HOLD:    if (wb_allowin) state_nx = capture ? capture_state : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: datapath registers are reset too, because they drive outputs that must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rd           <= '0;
      ld_q             <= 1'b0;
      we_q             <= 1'b0;
      uns_q            <= 1'b0;
      size_q           <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      computed_q       <= 1'b0;
      mem_result_value <= '0;
      mem_misalign     <= 1'b0;
      ram_dout         <= '0;
    end else if (capture) begin
      mem_rd           <= ie_rd;
      ld_q             <= is_load;
      we_q             <= is_store;
      uns_q            <= ie_mem_unsigned;
      size_q           <= result_mem_size;
      addr_q           <= result_mem_addr;
      wdata_q          <= wdata_in;
      wstrb_q          <= (is_store & aligned) ? wstrb_in : 4'b0000;
      computed_q       <= result_computed | result_link;
      mem_result_value <= result_link ? result_link_addr : result_value;
      mem_misalign     <= is_mem & ~aligned;
      ram_dout         <= '0;
    end else if ((state == ACCESS) && ram.ram_ack && ld_q) begin
      ram_dout <= load_fmt;
    end
  end

endmodule

// File: tb/tb_core_pipe_mem.sv
// Scoreboard bench for core_pipe_mem: a reference model predicts each result and
// RAM operation at drive time; a RAM responder and an output monitor check them.
module tb_core_pipe_mem;

  typedef struct {
    logic [4:0]  rd;
    logic        ld, st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, din;
    logic        comp;
    logic [31:0] val;
    logic        link;
    logic [31:0] laddr, rdata;
    int          lat;
  } txn_t;

  typedef struct {
    logic [4:0]  rd;
    logic        ld, comp;
    logic [31:0] val, dout;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata, rdata;
    int          lat;
  } op_t;

  logic        clk, rst_n;
  logic        ie_validout, mem_allowin;
  logic [4:0]  ie_rd;
  logic        result_mem_load, result_mem_store;
  logic [1:0]  result_mem_size;
  logic        ie_mem_unsigned;
  logic [31:0] result_mem_addr, result_mem_din;
  logic        result_computed;
  logic [31:0] result_value;
  logic        result_link;
  logic [31:0] result_link_addr;
  logic        mem_validout, wb_allowin;
  logic [4:0]  mem_rd;
  logic        mem_result_mem_load, mem_result_computed;
  logic [31:0] mem_result_value, ram_dout;
  logic        mem_misalign;

  core_pipe_mem_if bus ();

  core_pipe_mem dut (
    .clk(clk), .rst_n(rst_n),
    .ie_validout(ie_validout), .mem_allowin(mem_allowin),
    .ie_rd(ie_rd),
    .result_mem_load(result_mem_load), .result_mem_store(result_mem_store),
    .result_mem_size(result_mem_size), .ie_mem_unsigned(ie_mem_unsigned),
    .result_mem_addr(result_mem_addr), .result_mem_din(result_mem_din),
    .result_computed(result_computed), .result_value(result_value),
    .result_link(result_link), .result_link_addr(result_link_addr),
    .ram(bus.master),
    .mem_validout(mem_validout), .wb_allowin(wb_allowin),
    .mem_rd(mem_rd), .mem_result_mem_load(mem_result_mem_load),
    .mem_result_computed(mem_result_computed), .mem_result_value(mem_result_value),
    .ram_dout(ram_dout), .mem_misalign(mem_misalign)
  );

  int   checks = 0;
  int   errors = 0;
  int   req_cycles = 0;
  exp_t exp_q[$];
  op_t  op_q[$];
  bit   mon_en = 0;
  bit   wb_rand = 0;
  bit   wb_level = 1;
  bit   stray_ack = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane walk, independent of shift/replicate tricks.
  function automatic void model(input txn_t t, output exp_t e, output op_t o, output bit has_op);
    int nb, sh;
    bit ok, is_mem;
    logic [31:0] v;
    nb = (t.size == 2'b00) ? 1 : (t.size == 2'b01) ? 2 : 4;
    sh = int'(t.addr[1:0]);
    ok = (sh % nb) == 0;
    is_mem = t.ld || t.st;
    v = '0;
    if (t.ld && ok) begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = t.rdata[8*(sh+i) +: 8];
      if (!t.uns && nb < 4 && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    e.rd = t.rd; e.ld = t.ld; e.comp = t.comp | t.link;
    e.val = t.link ? t.laddr : t.val; e.dout = v; e.mis = is_mem && !ok;
    has_op = is_mem && ok;
    o.addr = t.addr & ~32'h3; o.we = t.st && !t.ld;
    o.wstrb = '0; o.wdata = '0; o.rdata = t.rdata; o.lat = t.lat;
    for (int j = 0; j < 4; j++) begin
      if (j >= sh && j < sh + nb) o.wstrb[j] = 1'b1;
      o.wdata[8*j +: 8] = t.din[8*(j % nb) +: 8];
    end
  endfunction

  function automatic txn_t blank();
    txn_t t;
    t.rd = '0; t.ld = 0; t.st = 0; t.size = 2'b10; t.uns = 0; t.addr = '0; t.din = '0;
    t.comp = 0; t.val = '0; t.link = 0; t.laddr = '0; t.rdata = '0; t.lat = 1;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    k = $urandom_range(0, 4);
    t = blank();
    t.rd = 5'($urandom); t.ld = (k == 2 || k == 4); t.st = (k == 3 || k == 4);
    t.size = 2'($urandom); t.uns = 1'($urandom); t.addr = $urandom; t.din = $urandom;
    t.comp = (k == 0); t.val = $urandom; t.link = (k == 1); t.laddr = $urandom;
    t.rdata = $urandom; t.lat = $urandom_range(1, 4);
    return t;
  endfunction

  // Called just after a rising edge: presents the instruction and records predictions.
  task automatic drive(input txn_t t);
    exp_t e; op_t o; bit h;
    ie_rd = t.rd; result_mem_load = t.ld; result_mem_store = t.st;
    result_mem_size = t.size; ie_mem_unsigned = t.uns;
    result_mem_addr = t.addr; result_mem_din = t.din;
    result_computed = t.comp; result_value = t.val;
    result_link = t.link; result_link_addr = t.laddr;
    ie_validout = 1'b1;
    model(t, e, o, h);
    exp_q.push_back(e);
    if (h) op_q.push_back(o);
  endtask

  task automatic send(input txn_t t);
    int n;
    drive(t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_allowin && n < 200);
    check("capture_wait", mem_allowin, 1'b1);
    @(posedge clk);
    #1 ie_validout = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    wb_allowin = 1'b1;
    forever begin
      @(posedge clk);
      #2 wb_allowin = wb_rand ? ($urandom_range(0, 3) != 0) : wb_level;
    end
  end

  // Data-RAM responder: acks after the per-op latency, checks request and its stability.
  initial begin
    int cnt;
    bit ack_n;
    op_t cur;
    logic [68:0] snap;
    cnt = 0;
    bus.ram_ack = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(negedge clk);
      ack_n = 1'b0;
      if (mon_en && bus.ram_req) begin
        if (cnt == 0) begin
          check("ram_req_expected", op_q.size() != 0, 1'b1);
          if (op_q.size() != 0) cur = op_q[0];
          snap = {bus.ram_addr, bus.ram_we, bus.ram_wstrb, bus.ram_wdata};
        end else begin
          check("ram_stable", {bus.ram_addr, bus.ram_we, bus.ram_wstrb, bus.ram_wdata}, snap);
        end
        cnt++;
        req_cycles++;
        bus.ram_rdata = cur.rdata;
        if (cnt >= cur.lat) begin
          ack_n = 1'b1;
          check("ram_addr", bus.ram_addr, cur.addr);
          check("ram_we", bus.ram_we, cur.we);
          if (cur.we) begin
            check("ram_wstrb", bus.ram_wstrb, cur.wstrb);
            check("ram_wdata", bus.ram_wdata, cur.wdata);
          end
          if (op_q.size() != 0) void'(op_q.pop_front());
        end
      end else begin
        cnt = 0;
      end
      bus.ram_ack = ack_n | stray_ack;
    end
  end

  // Output monitor: a result transfers at the next edge when valid and accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!mem_validout)
          check("fwd_gated", {mem_result_mem_load, mem_result_computed}, 2'b00);
        if (mem_validout && wb_allowin) begin
          check("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mem_rd", mem_rd, e.rd);
            check("mem_load", mem_result_mem_load, e.ld);
            check("mem_computed", mem_result_computed, e.comp);
            check("mem_value", mem_result_value, e.val);
            check("ram_dout", ram_dout, e.dout);
            check("mem_misalign", mem_misalign, e.mis);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int r0;
    rst_n = 1'b0;
    ie_validout = 1'b0; ie_rd = '0; result_mem_load = 0; result_mem_store = 0;
    result_mem_size = '0; ie_mem_unsigned = 0; result_mem_addr = '0; result_mem_din = '0;
    result_computed = 0; result_value = '0; result_link = 0; result_link_addr = '0;

    repeat (3) @(posedge clk);
    mon_en = 1;
    #1;
    check("rst_validout", mem_validout, 1'b0);
    check("rst_ram_req", bus.ram_req, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_misalign", mem_misalign, 1'b0);
    check("rst_wstrb", bus.ram_wstrb, 4'b0000);
    check("rst_dout", ram_dout, 32'h0);
    check("rst_value", mem_result_value, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_allowin", mem_allowin, 1'b1);
    @(posedge clk);
    #1;

    // ALU result: valid one cycle after capture, no RAM traffic
    r0 = req_cycles;
    t = blank(); t.rd = 5'd3; t.comp = 1; t.val = 32'h5;
    send(t);
    check("add_valid", mem_validout, 1'b1);
    check("add_noreq", bus.ram_req, 1'b0);
    wait_drain();
    check("add_req_cycles", req_cycles - r0, 0);

    // LB signed then unsigned, 3-cycle ack
    r0 = req_cycles;
    t = blank(); t.rd = 5'd4; t.ld = 1; t.size = 2'b00; t.addr = 32'h1003;
    t.rdata = 32'h80FF_FFFF; t.lat = 3;
    send(t);
    wait_drain();
    check("lb_req_cycles", req_cycles - r0, 3);
    t.uns = 1;
    send(t);
    wait_drain();

    // SH, lane-replicated write
    t = blank(); t.rd = 5'd0; t.st = 1; t.size = 2'b01; t.addr = 32'h2002;
    t.din = 32'hABCD_1234; t.lat = 2;
    send(t);
    wait_drain();

    // Misaligned LW
    r0 = req_cycles;
    t = blank(); t.rd = 5'd6; t.ld = 1; t.size = 2'b10; t.addr = 32'h3001; t.rdata = 32'hDEAD_BEEF;
    send(t);
    check("mis_valid", mem_validout, 1'b1);
    check("mis_noreq", bus.ram_req, 1'b0);
    wait_drain();
    check("mis_req_cycles", req_cycles - r0, 0);

    // Writeback stall for 4 cycles, then same-cycle capture on release
    wb_level = 0;
    t = blank(); t.rd = 5'd7; t.comp = 1; t.val = 32'h1234;
    send(t);
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", mem_validout, 1'b1);
      check("stall_allowin", mem_allowin, 1'b0);
      check("stall_rd", mem_rd, 5'd7);
      check("stall_value", mem_result_value, 32'h1234);
    end
    @(posedge clk);
    #1;
    t = blank(); t.rd = 5'd9; t.link = 1; t.laddr = 32'h99; t.val = 32'h77;
    drive(t);
    wb_level = 1;
    @(negedge clk);
    check("release_allowin", mem_allowin, 1'b1);
    @(posedge clk);
    #1 ie_validout = 1'b0;
    check("release_valid", mem_validout, 1'b1);
    check("release_rd", mem_rd, 5'd9);
    wait_drain();

    // Random mix with random writeback backpressure
    wb_rand = 1;
    for (int i = 0; i < 80; i++) send(rand_txn());
    wait_drain();
    wb_rand = 0;
    @(posedge clk);
    #1;

    // Reset during ACCESS, then a stray ack
    t = blank(); t.rd = 5'd2; t.ld = 1; t.addr = 32'h4000; t.lat = 50;
    send(t);
    @(negedge clk);
    check("acc_req", bus.ram_req, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("acc_rst_req", bus.ram_req, 1'b0);
    check("acc_rst_valid", mem_validout, 1'b0);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    void'(op_q.pop_back());
    stray_ack = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("stray_req", bus.ram_req, 1'b0);
      check("stray_valid", mem_validout, 1'b0);
      check("stray_allowin", mem_allowin, 1'b1);
    end
    stray_ack = 0;
    t = blank(); t.rd = 5'd12; t.comp = 1; t.val = 32'hCAFE;
    send(t);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_pipe_mem.md
CORE_PIPE_MEM -- requirements
Module: core_pipe_mem

Interface
REQ-001 Reset is synchronous and active-low. There is one clock.
REQ-002 clk  input  1  stage clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 ie_validout  input  1  the execute stage holds a valid instruction.
REQ-005 mem_allowin  output  1  this stage accepts an instruction this cycle.
REQ-006 ie_rd  input  5  destination register.
REQ-007 result_mem_load / result_mem_store  input  1 each  load or store request.
REQ-008 result_mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 ie_mem_unsigned  input  1  zero-extend load data (func3[2]).
REQ-010 result_mem_addr / result_mem_din  input  32 each  byte address; store data in the low bits.
REQ-011 result_computed / result_value  input  1 / 32  ALU writeback request and its value.
REQ-012 result_link / result_link_addr  input  1 / 32  jump-and-link writeback request and its value.
REQ-013 ram_req  output  1  data-RAM request.
REQ-014 ram_we  output  1  data-RAM write enable.
REQ-015 ram_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 ram_wdata / ram_wstrb  output  32 / 4  lane-replicated write data; byte strobes.
REQ-017 ram_ack / ram_rdata  input  1 / 32  access complete; read word, valid with ack.
REQ-018 mem_validout / wb_allowin  output / input  1 each  result valid to writeback; writeback accepts.
REQ-019 mem_rd, mem_result_mem_load, mem_result_computed, mem_result_value, ram_dout, mem_misalign  outputs  5,1,1,32,32,1  forwarding and writeback bundle.

Function
REQ-020 The stage SHALL use a state machine with three states: IDLE, ACCESS and HOLD.
REQ-021 The stage SHALL drive mem_allowin = (IDLE & !mem_validout) | (HOLD & wb_allowin).
REQ-022 Capture SHALL occur when ie_validout & mem_allowin.
REQ-023 On capture, all inputs SHALL be registered.
REQ-024 A captured non-memory instruction SHALL go to HOLD, with mem_validout=1 on the next cycle.
REQ-025 A captured aligned load or store SHALL go to ACCESS and SHALL assert ram_req from the next cycle.
REQ-026 In ACCESS, ram_req, ram_we, ram_addr, ram_wdata and ram_wstrb SHALL be held stable until the cycle in which ram_ack=1.
REQ-027 ram_ack SHALL be ignored outside ACCESS.
REQ-028 On ram_ack, the stage SHALL go to HOLD and SHALL assert mem_validout on the next cycle.
REQ-029 A load SHALL register the formatted ram_rdata into ram_dout.
REQ-030 ram_req SHALL deassert in the cycle after ram_ack.
REQ-031 In HOLD with wb_allowin=1, mem_validout SHALL drop, or be replaced by the simultaneously captured instruction.
REQ-032 In HOLD with wb_allowin=0, all outputs SHALL be frozen.
REQ-033 Alignment is required as follows: half needs addr[0]=0; word needs addr[1:0]=00.
REQ-034 A misaligned access SHALL issue no RAM request, SHALL go directly to HOLD, and SHALL set mem_misalign=1.
REQ-035 A misaligned load SHALL return ram_dout=0. A misaligned store SHALL write nothing.
REQ-036 Byte strobes SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word.
REQ-037 ram_wdata SHALL be the byte replicated ×4, the half replicated ×2, or the word.
REQ-038 Load formatting SHALL select the lane addressed by addr[1:0], then sign-extend, or zero-extend if ie_mem_unsigned=1.
REQ-039 mem_result_value SHALL be result_link_addr when result_link=1, otherwise result_value.
REQ-040 mem_result_computed SHALL equal result_computed | result_link.
REQ-041 The forwarding outputs mem_result_mem_load and mem_result_computed SHALL be 0 whenever mem_validout=0.
REQ-042 Both load and store set simultaneously is illegal input; the stage SHALL treat it as a load.

Reset
REQ-043 With rst_n=0 at a clock edge, the stage SHALL go to IDLE.
REQ-044 On reset, mem_validout, ram_req, ram_we, mem_result_mem_load, mem_result_computed and mem_misalign SHALL be 0.
REQ-045 On reset, ram_wstrb SHALL be 0, and ram_dout and mem_result_value SHALL be 0.
REQ-046 Reset in ACCESS SHALL abandon the transaction, with ram_req=0 on the next cycle. A later ram_ack SHALL be ignored.
REQ-047 The cycle after reset release, mem_allowin SHALL be 1.

Verification
REQ-048 ADD result 0x5, rd=3, wb_allowin=1 -> one cycle later mem_validout=1, mem_result_computed=1, mem_result_value=0x5, mem_rd=3; no ram_req.
REQ-049 LB addr 0x1003, ram_rdata 0x80FF_FFFF, ack after 3 cycles -> ram_addr=0x1000 held 3 cycles; ram_dout=0xFFFF_FF80; with unsigned=1 -> 0x80.
REQ-050 SH addr 0x2002, din 0xABCD1234 -> ram_we=1, ram_wstrb=1100, ram_wdata=0x12341234.
REQ-051 LW addr 0x3001 -> no ram_req, mem_misalign=1, ram_dout=0, mem_validout next cycle.
REQ-052 Result held while wb_allowin=0 for 4 cycles -> outputs frozen and mem_allowin=0; when wb_allowin rises, the next instruction is captured in the same cycle.
REQ-053 rst_n=0 during ACCESS, then ram_ack -> ram_req=0, state IDLE, mem_validout stays 0.
